// File: rtl/collector_uart.sv
// 8N1 UART receiver with a byte-stream output (tdata/tvalid/tready), framing and overrun pulses.
// Define COLLECTOR_UART_PARITY_EN for 8E1 frames with an extra o_parity_err pulse output.
module collector_uart #(
   parameter int clk_freq_hz = 16_000_000,
   parameter int baud_rate   = 57_600
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_uart_rx,
   output logic [7:0] o_tdata,
   output logic       o_tvalid,
   input  logic       i_tready,
   output logic       o_frame_err,
   output logic       o_overrun
`ifdef COLLECTOR_UART_PARITY_EN
   ,
   output logic       o_parity_err
`endif
);

   localparam int DIV  = clk_freq_hz / baud_rate;
   localparam int HALF = DIV / 2;
   localparam int CW   = $clog2(DIV);
   localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
   localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_IDLE
`ifdef COLLECTOR_UART_PARITY_EN
      ,
      PARITY
`endif
   } state_t;

   state_t          state_reg;
   logic [1:0]      sync_reg;
   logic [CW-1:0]   cnt_reg;
   logic [2:0]      bit_idx_reg;
   logic [7:0]      shift_reg;
   logic            rx_s;
`ifdef COLLECTOR_UART_PARITY_EN
   logic            par_bad_reg;
`endif

   assign rx_s = sync_reg[1];

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_reg   <= IDLE;
         sync_reg    <= 2'b11;
         cnt_reg     <= '0;
         bit_idx_reg <= '0;
         shift_reg   <= '0;
         o_tdata     <= '0;
         o_tvalid    <= 1'b0;
         o_frame_err <= 1'b0;
         o_overrun   <= 1'b0;
`ifdef COLLECTOR_UART_PARITY_EN
         par_bad_reg  <= 1'b0;
         o_parity_err <= 1'b0;
`endif
      end else begin
         sync_reg    <= {sync_reg[0], i_uart_rx};
         o_frame_err <= 1'b0;
         o_overrun   <= 1'b0;
`ifdef COLLECTOR_UART_PARITY_EN
         o_parity_err <= 1'b0;
`endif
         // A deliver later in this block overrides this clear (back-to-back accept).
         if (o_tvalid && i_tready)
            o_tvalid <= 1'b0;

         case (state_reg)
            IDLE: begin
               if (!rx_s) begin
                  state_reg <= START;
                  cnt_reg   <= HALF_M1;
               end
            end
            START: begin
               if (cnt_reg == '0) begin
                  if (!rx_s) begin
                     state_reg   <= DATA;
                     cnt_reg     <= DIV_M1;
                     bit_idx_reg <= '0;
                  end else begin
                     state_reg <= IDLE;
                  end
               end else begin
                  cnt_reg <= cnt_reg - 1'b1;
               end
            end
            DATA: begin
               if (cnt_reg == '0) begin
                  shift_reg <= {rx_s, shift_reg[7:1]};
                  cnt_reg   <= DIV_M1;
                  if (bit_idx_reg == 3'd7) begin
`ifdef COLLECTOR_UART_PARITY_EN
                     state_reg <= PARITY;
`else
                     state_reg <= STOP;
`endif
                  end else begin
                     bit_idx_reg <= bit_idx_reg + 1'b1;
                  end
               end else begin
                  cnt_reg <= cnt_reg - 1'b1;
               end
            end
`ifdef COLLECTOR_UART_PARITY_EN
            PARITY: begin
               if (cnt_reg == '0) begin
                  par_bad_reg  <= ^{shift_reg, rx_s};
                  o_parity_err <= ^{shift_reg, rx_s};
                  cnt_reg      <= DIV_M1;
                  state_reg    <= STOP;
               end else begin
                  cnt_reg <= cnt_reg - 1'b1;
               end
            end
`endif
            STOP: begin
               if (cnt_reg == '0) begin
                  if (rx_s) begin
                     state_reg <= IDLE;
`ifdef COLLECTOR_UART_PARITY_EN
                     if (!par_bad_reg) begin
`else
                     begin
`endif
                        if (!o_tvalid || i_tready) begin
                           o_tdata  <= shift_reg;
                           o_tvalid <= 1'b1;
                        end else begin
                           o_overrun <= 1'b1;
                        end
                     end
                  end else begin
                     // Line still low at stop: wait for idle so a break is not read as 0x00 bytes.
                     o_frame_err <= 1'b1;
                     state_reg   <= WAIT_IDLE;
                  end
               end else begin
                  cnt_reg <= cnt_reg - 1'b1;
               end
            end
            WAIT_IDLE: begin
               if (rx_s)
                  state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_collector_uart.sv
// Self-checking bench for collector_uart: vector table plus hand sequences, scoreboard on accepted bytes.
module tb_collector_uart;

   localparam int DIV  = 16;
   localparam int HALF = 8;
`ifdef COLLECTOR_UART_PARITY_EN
   localparam int PBITS = 1;
`else
   localparam int PBITS = 0;
`endif
   // Start bit driven just after posedge c0 (so T0 = c0+1); o_tvalid is first seen at the negedge after posedge c0+LAT.
   localparam int LAT = HALF + 3 + (9 + PBITS) * DIV;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx = 1'b1;
   logic       tready = 1'b0;
   logic [7:0] tdata;
   logic       tvalid;
   logic       ferr;
   logic       ovr;
`ifdef COLLECTOR_UART_PARITY_EN
   logic       perr;
   logic       par_invert = 1'b0;
`endif

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   collector_uart #(.clk_freq_hz(16_000_000), .baud_rate(1_000_000)) dut (
      .i_clk(clk),
      .i_rst_n(rst_n),
      .i_uart_rx(rx),
      .o_tdata(tdata),
      .o_tvalid(tvalid),
      .i_tready(tready),
      .o_frame_err(ferr),
      .o_overrun(ovr)
`ifdef COLLECTOR_UART_PARITY_EN
      ,
      .o_parity_err(perr)
`endif
   );

   int tests = 0;
   int fails = 0;
   logic [7:0] exp_q[$];
   int n_xfer = 0, n_ferr = 0, n_ovr = 0, n_perr = 0;
   int rise_cyc = -1, ovr_cyc = -1, last_len = 0, cur_len = 0;
   logic prev_valid = 1'b0, prev_xfer = 1'b0, prev_ferr = 1'b0, prev_ovr = 1'b0, prev_perr = 1'b0;
   logic [7:0] prev_data = '0;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: scoreboard pops on every accepted byte; pulse widths and output hold are checked here.
   always @(negedge clk) begin
      if (rst_n) begin
         if (tvalid && !prev_valid) rise_cyc = cyc;
         if (tvalid) cur_len++;
         else begin
            if (prev_valid) last_len = cur_len;
            cur_len = 0;
         end
         if (prev_valid && !prev_xfer) begin
            check("tvalid_hold", int'(tvalid), 1);
            check("tdata_hold", int'(tdata), int'(prev_data));
         end
         if (tvalid && tready) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_byte: got 0x%02h, expected no byte", tdata);
            end else begin
               check("tdata", int'(tdata), int'(exp_q.pop_front()));
            end
            n_xfer++;
         end
         if (ferr) begin check("ferr_width", int'(prev_ferr), 0); n_ferr++; end
         if (ovr) begin check("ovr_width", int'(prev_ovr), 0); n_ovr++; ovr_cyc = cyc; end
`ifdef COLLECTOR_UART_PARITY_EN
         if (perr) begin check("perr_width", int'(prev_perr), 0); n_perr++; end
         prev_perr = perr;
`endif
         prev_valid = tvalid;
         prev_xfer  = tvalid && tready;
         prev_ferr  = ferr;
         prev_ovr   = ovr;
         prev_data  = tdata;
      end else begin
         prev_valid = 1'b0;
         prev_xfer  = 1'b0;
         prev_ferr  = 1'b0;
         prev_ovr   = 1'b0;
         prev_perr  = 1'b0;
         cur_len    = 0;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_bit(input logic b);
      rx = b;
      tick(DIV);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop, output int c0);
      c0 = cyc;
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef COLLECTOR_UART_PARITY_EN
      send_bit(^d ^ par_invert);
`endif
      send_bit(stop);
   endtask

   typedef struct {
      logic [7:0] data;
      logic       stop;
      logic       exp_valid;
      logic       exp_ferr;
   } vec_t;

   vec_t vecs[5];

   initial begin
      int c0, c1, x0, f0, o0, p0;

      vecs[0] = '{data: 8'h55, stop: 1'b1, exp_valid: 1'b1, exp_ferr: 1'b0};
      vecs[1] = '{data: 8'h00, stop: 1'b1, exp_valid: 1'b1, exp_ferr: 1'b0};
      vecs[2] = '{data: 8'hFF, stop: 1'b1, exp_valid: 1'b1, exp_ferr: 1'b0};
      vecs[3] = '{data: 8'hA5, stop: 1'b0, exp_valid: 1'b0, exp_ferr: 1'b1};
      vecs[4] = '{data: 8'h6E, stop: 1'b1, exp_valid: 1'b1, exp_ferr: 1'b0};

      rst_n = 1'b0;
      tick(4);
      check("rst_tdata", int'(tdata), 0);
      check("rst_tvalid", int'(tvalid), 0);
      check("rst_ferr", int'(ferr), 0);
      check("rst_ovr", int'(ovr), 0);
      rst_n = 1'b1;
      tick(2);
      check("post_rst_pulses", int'(ferr | ovr), 0);

      // Table: single frames with the consumer always ready.
      tready = 1'b1;
      foreach (vecs[k]) begin
         x0 = n_xfer; f0 = n_ferr; o0 = n_ovr;
         rise_cyc = -1;
         if (vecs[k].exp_valid) exp_q.push_back(vecs[k].data);
         send_frame(vecs[k].data, vecs[k].stop, c0);
         rx = 1'b1;
         tick(2 * DIV);
         $display("[TB] vec %0d: byte 0x%02h stop %0d -> xfer %0d ferr %0d", k, vecs[k].data,
                  vecs[k].stop, n_xfer - x0, n_ferr - f0);
         check("vec_xfer", n_xfer - x0, int'(vecs[k].exp_valid));
         check("vec_ferr", n_ferr - f0, int'(vecs[k].exp_ferr));
         check("vec_ovr", n_ovr - o0, 0);
         if (vecs[k].exp_valid) begin
            check("vec_latency", rise_cyc - c0, LAT);
            check("vec_valid_len", last_len, 1);
         end
      end

      // Overrun: two back-to-back frames into a stalled consumer.
      tready = 1'b0;
      x0 = n_xfer; o0 = n_ovr;
      exp_q.push_back(8'hA3);
      send_frame(8'hA3, 1'b1, c0);
      send_frame(8'h0F, 1'b1, c1);
      tick(2 * DIV);
      $display("[TB] overrun seq: ovr %0d tdata 0x%02h tvalid %0d", n_ovr - o0, tdata, tvalid);
      check("ovr_count", n_ovr - o0, 1);
      check("ovr_cycle", ovr_cyc - c1, LAT);
      check("ovr_tvalid", int'(tvalid), 1);
      check("ovr_tdata", int'(tdata), 8'hA3);
      check("ovr_no_xfer", n_xfer - x0, 0);
      tready = 1'b1;
      tick(1);
      check("ovr_accept", n_xfer - x0, 1);
      check("ovr_tvalid_drop", int'(tvalid), 0);

      // Short low glitch while idle must be rejected silently.
      x0 = n_xfer; f0 = n_ferr; o0 = n_ovr;
      rx = 1'b0;
      tick(5);
      rx = 1'b1;
      tick(3 * DIV);
      $display("[TB] glitch seq: xfer %0d ferr %0d ovr %0d", n_xfer - x0, n_ferr - f0, n_ovr - o0);
      check("glitch_quiet", (n_xfer - x0) + (n_ferr - f0) + (n_ovr - o0), 0);
      exp_q.push_back(8'h81);
      send_frame(8'h81, 1'b1, c0);
      tick(2 * DIV);
      check("glitch_then_rx", n_xfer - x0, 1);

      // Framing error followed by a long break, then a good frame.
      x0 = n_xfer; f0 = n_ferr;
      send_frame(8'h3C, 1'b0, c0);
      tick(50);
      $display("[TB] break seq: ferr %0d xfer %0d", n_ferr - f0, n_xfer - x0);
      check("brk_ferr", n_ferr - f0, 1);
      check("brk_no_xfer", n_xfer - x0, 0);
      check("brk_tvalid", int'(tvalid), 0);
      rx = 1'b1;
      tick(2 * DIV);
      exp_q.push_back(8'hC3);
      send_frame(8'hC3, 1'b1, c0);
      tick(2 * DIV);
      check("brk_recover", n_xfer - x0, 1);
      check("brk_ferr_total", n_ferr - f0, 1);

      // Reset in the middle of a 0xFF frame; only the following 0x12 may appear.
      x0 = n_xfer;
      rx = 1'b0;
      tick(DIV);
      rx = 1'b1;
      tick(3 * DIV);
      rst_n = 1'b0;
      tick(3);
      check("mid_rst_tvalid", int'(tvalid), 0);
      check("mid_rst_tdata", int'(tdata), 0);
      rst_n = 1'b1;
      tick(6 * DIV);
      exp_q.push_back(8'h12);
      send_frame(8'h12, 1'b1, c0);
      tick(2 * DIV);
      $display("[TB] mid-reset seq: xfer %0d", n_xfer - x0);
      check("mid_rst_xfer", n_xfer - x0, 1);

`ifdef COLLECTOR_UART_PARITY_EN
      // Even parity: 0x07 carries parity bit 1 when valid.
      x0 = n_xfer; p0 = n_perr; f0 = n_ferr;
      rise_cyc = -1;
      exp_q.push_back(8'h07);
      par_invert = 1'b0;
      send_frame(8'h07, 1'b1, c0);
      tick(2 * DIV);
      check("par_ok_xfer", n_xfer - x0, 1);
      check("par_ok_latency", rise_cyc - c0, LAT);
      check("par_ok_perr", n_perr - p0, 0);
      par_invert = 1'b1;
      send_frame(8'h07, 1'b1, c0);
      par_invert = 1'b0;
      tick(2 * DIV);
      $display("[TB] parity seq: perr %0d xfer %0d", n_perr - p0, n_xfer - x0);
      check("par_bad_perr", n_perr - p0, 1);
      check("par_bad_xfer", n_xfer - x0, 1);
      check("par_bad_ferr", n_ferr - f0, 0);
      check("par_bad_tvalid", int'(tvalid), 0);
`else
      p0 = n_perr;
      check("no_parity_pulses", n_perr - p0, 0);
`endif

      check("queue_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
